// File: rtl/host_monitor_pkg.sv
// Shared types and constants for the host monitor block.
package host_wires;

    // Run state of the test being monitored; DONE and TIMEOUT hold until reset.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DONE    = 2'd1,
        TIMEOUT = 2'd2
    } host_state_t;

    // Exit code reported when software issues an (unsupported) syscall via tohost.
    localparam logic [30:0] HOST_SYSCALL_CODE = 31'h7FFF_FFFF;

endpackage

// File: rtl/host_fifo.sv
// First-word fall-through FIFO buffering the console byte stream.
// The head entry is visible on rdata whenever empty is low.
module host_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~pop;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge clock) begin
        // NOTE: the array is deliberately not reset; count gates every read, so stale data is never seen.
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/host_monitor.sv
// Snoops the data-memory bus for tohost (pass/fail/exit code) and console writes.
// Console bytes are buffered in host_fifo and drained through a valid/ready port.
// Define HOST_WATCHDOG_EN to build a cycle watchdog that ends runaway tests after
// TIMEOUT cycles; without it, timeout is tied low and no counter exists.
module host_monitor
    import host_wires::*;
#(
    parameter logic [31:0] HOST_ADDR  = 32'h0000_1000,
    parameter logic [31:0] CONS_ADDR  = 32'h0000_1004,
    parameter int          FIFO_DEPTH = 8,
    parameter int          TIMEOUT    = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    output logic        cons_valid,
    input  logic        cons_ready,
    output logic [7:0]  cons_data,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic        overflow,
    output logic [30:0] exit_code
);

    // Reject illegal configurations at elaboration time.
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("host_monitor: FIFO_DEPTH must be a power of two in 2..256");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("host_monitor: TIMEOUT must be at least 1");
    end

    host_state_t state_q, state_d;
    logic [30:0] exit_q, exit_d;
    logic        overflow_q;

    logic        wr;
    logic        host_hit;
    logic        cons_hit;
    logic [1:0]  lane;
    logic [7:0]  lane_byte;
    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_drop;

    // Bus decode: only accepted writes count; tohost wins if both addresses match.
    assign wr        = mem_valid & mem_ready & (|mem_wstrb);
    assign host_hit  = wr & (mem_addr[31:2] == HOST_ADDR[31:2]);
    assign cons_hit  = wr & (mem_addr[31:2] == CONS_ADDR[31:2]) & ~host_hit;
    assign lane      = mem_addr[1:0];
    assign lane_byte = mem_wdata[{lane, 3'b000} +: 8];
    assign push      = (state_q == RUN) & cons_hit & mem_wstrb[lane];
    assign pop       = cons_valid & cons_ready;

    host_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (lane_byte),
        .rdata (cons_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

`ifdef HOST_WATCHDOG_EN
    logic [31:0] wd_cnt;

    // Watchdog counts cycles spent in RUN since reset release.
    always_ff @(posedge clock) begin
        if (!reset)              wd_cnt <= '0;
        else if (state_q == RUN) wd_cnt <= wd_cnt + 1'b1;
    end
`endif

    // State register with the captured exit code and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= RUN;
            exit_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            exit_q     <= exit_d;
            overflow_q <= overflow_q | fifo_drop;
        end
    end

    // Next state: tohost decode first, so it beats a watchdog expiry on the same cycle.
    always_comb begin
        // NOTE: defaults first keep every path assigned, so no latch is inferred.
        state_d = state_q;
        exit_d  = exit_q;
        case (state_q)
            RUN: begin
                if (host_hit && mem_wdata[0]) begin
                    state_d = DONE;
                    exit_d  = mem_wdata[31:1];
                end else if (host_hit && (mem_wdata != 32'd0)) begin
                    state_d = DONE;
                    exit_d  = HOST_SYSCALL_CODE;
                end
`ifdef HOST_WATCHDOG_EN
                else if (wd_cnt == 32'(TIMEOUT - 1)) begin
                    state_d = host_wires::TIMEOUT;
                end
`endif
            end
            default: ;
        endcase
    end

    // Outputs derive only from registered state, so they appear one cycle after the event.
    always_comb begin
        done       = (state_q != RUN);
        timeout    = (state_q == host_wires::TIMEOUT);
        pass       = (state_q == DONE) && (exit_q == '0);
        exit_code  = exit_q;
        overflow   = overflow_q;
        cons_valid = ~fifo_empty;
    end

endmodule

// File: tb/tb_host_monitor.sv
// Self-checking bench for host_monitor: a queue-based behavioural model is compared
// against the DUT every cycle, plus directed checks with hand-computed values.
// Works with and without HOST_WATCHDOG_EN (the DUT is built with TIMEOUT=20).
module tb_host_monitor;

    localparam logic [31:0] HOST_A = 32'h0000_1000;
    localparam logic [31:0] CONS_A = 32'h0000_1004;
    localparam int          DEPTH  = 8;
    localparam int          TMO    = 20;

    logic        clock;
    logic        reset;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        cons_valid;
    logic        cons_ready;
    logic [7:0]  cons_data;
    logic        done;
    logic        pass;
    logic        timeout;
    logic        overflow;
    logic [30:0] exit_code;

    int checks = 0;
    int errors = 0;

    host_monitor #(
        .HOST_ADDR  (HOST_A),
        .CONS_ADDR  (CONS_A),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .cons_valid (cons_valid),
        .cons_ready (cons_ready),
        .cons_data  (cons_data),
        .done       (done),
        .pass       (pass),
        .timeout    (timeout),
        .overflow   (overflow),
        .exit_code  (exit_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_run     = 1'b1;
    bit          m_done    = 1'b0;
    bit          m_pass    = 1'b0;
    bit          m_tmo     = 1'b0;
    bit          m_ovf     = 1'b0;
    logic [30:0] m_exit    = '0;
    int          m_cycles  = 0;
    logic [7:0]  m_q[$];
    bit          m_wr, m_hhit, m_chit, m_fin;
    logic [7:0]  m_byte;

    always @(posedge clock) begin
        if (!reset) begin
            m_run = 1'b1; m_done = 1'b0; m_pass = 1'b0; m_tmo = 1'b0;
            m_ovf = 1'b0; m_exit = '0; m_cycles = 0;
            m_q.delete();
        end else begin
            m_wr   = mem_valid && mem_ready && (mem_wstrb != 4'd0);
            m_hhit = m_wr && ((mem_addr >> 2) == (HOST_A >> 2));
            m_chit = m_wr && !m_hhit && ((mem_addr >> 2) == (CONS_A >> 2));
            m_fin  = 1'b0;
            if (m_q.size() > 0 && cons_ready) void'(m_q.pop_front());
            if (m_run && m_chit && mem_wstrb[mem_addr[1:0]]) begin
                m_byte = 8'(mem_wdata >> (8 * int'(mem_addr[1:0])));
                if (m_q.size() < DEPTH) m_q.push_back(m_byte);
                else                    m_ovf = 1'b1;
            end
            if (m_run && m_hhit) begin
                if (mem_wdata % 2 == 1) begin
                    m_fin  = 1'b1;
                    m_exit = 31'(mem_wdata / 2);
                    m_pass = (m_exit == 0);
                end else if (mem_wdata != 0) begin
                    m_fin  = 1'b1;
                    m_exit = 31'h7FFF_FFFF;
                    m_pass = 1'b0;
                end
            end
`ifdef HOST_WATCHDOG_EN
            if (m_run && !m_fin && m_cycles == TMO - 1) begin
                m_fin = 1'b1;
                m_tmo = 1'b1;
            end
`endif
            if (m_run) m_cycles++;
            if (m_fin) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, just after the active edge.
    always @(posedge clock) begin
        #1;
        check("m_done",       32'(done),       32'(m_done));
        check("m_pass",       32'(pass),       32'(m_pass));
        check("m_timeout",    32'(timeout),    32'(m_tmo));
        check("m_overflow",   32'(overflow),   32'(m_ovf));
        check("m_exit_code",  32'(exit_code),  32'(m_exit));
        check("m_cons_valid", 32'(cons_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) check("m_cons_data", 32'(cons_data), 32'(m_q[0]));
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic do_reset();
        mem_valid = 1'b0; mem_ready = 1'b0; mem_wstrb = 4'd0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic write_bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        mem_valid = 1'b1; mem_ready = 1'b1;
        mem_addr  = a; mem_wstrb = s; mem_wdata = d;
        @(negedge clock);
        mem_valid = 1'b0; mem_ready = 1'b0; mem_wstrb = 4'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        mem_valid = 1'b0; mem_ready = 1'b0; mem_addr = '0; mem_wstrb = '0; mem_wdata = '0;
        cons_ready = 1'b0; reset = 1'b0;

        // Reset state
        do_reset();
        check("rst_done",  32'(done), 0);
        check("rst_valid", 32'(cons_valid), 0);
        check("rst_exit",  32'(exit_code), 0);

        // Test 1: pass, later writes change nothing
        write_bus(HOST_A, 4'hF, 32'h1);
        check("t1_done", 32'(done), 1);
        check("t1_pass", 32'(pass), 1);
        check("t1_exit", 32'(exit_code), 0);
        write_bus(HOST_A, 4'hF, 32'h3);
        check("t1_sticky_pass", 32'(pass), 1);
        check("t1_sticky_exit", 32'(exit_code), 0);

        // Zero write and reads are ignored; then exit code 3
        do_reset();
        write_bus(HOST_A, 4'hF, 32'h0);
        check("zero_ignored", 32'(done), 0);
        write_bus(HOST_A, 4'h0, 32'h7);
        check("read_ignored", 32'(done), 0);
        write_bus(HOST_A, 4'hF, 32'h7);
        check("t2_done", 32'(done), 1);
        check("t2_pass", 32'(pass), 0);
        check("t2_exit", 32'(exit_code), 3);

        // Syscall (even, nonzero)
        do_reset();
        write_bus(HOST_A, 4'hF, 32'h2);
        check("sys_done", 32'(done), 1);
        check("sys_pass", 32'(pass), 0);
        check("sys_exit", 32'(exit_code), 32'h7FFF_FFFF);

        // Test 3: console lanes
        do_reset();
        cons_ready = 1'b1;
        write_bus(CONS_A + 1, 4'b0010, 32'h0000_4800);
        check("t3_valid_h", 32'(cons_valid), 1);
        check("t3_data_h",  32'(cons_data), 32'h48);
        write_bus(CONS_A + 1, 4'b0010, 32'h0000_6900);
        check("t3_data_i",  32'(cons_data), 32'h69);
        write_bus(CONS_A + 1, 4'b0001, 32'h0000_5500);
        check("t3_wrong_lane", 32'(cons_valid), 0);
        write_bus(CONS_A + 3, 4'b1000, 32'h4100_0000);
        check("t3_lane3", 32'(cons_data), 32'h41);
        @(negedge clock);

        // Test 4: overflow, ordered drain, push+pop while full
        do_reset();
        cons_ready = 1'b0;
        for (int i = 0; i < 9; i++) write_bus(CONS_A, 4'b0001, 32'(8'h30 + i));
        check("t4_overflow", 32'(overflow), 1);
        cons_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t4_drain_valid", 32'(cons_valid), 1);
            check("t4_drain_data",  32'(cons_data), 32'(8'h30 + i));
            @(negedge clock);
        end
        check("t4_drained", 32'(cons_valid), 0);
        cons_ready = 1'b0;
        for (int i = 0; i < 8; i++) write_bus(CONS_A, 4'b0001, 32'(8'h40 + i));
        cons_ready = 1'b1;
        write_bus(CONS_A, 4'b0001, 32'h48);
        check("t4_full_pp_head", 32'(cons_data), 32'h41);
        n = 0;
        while (cons_valid && n < 20) begin
            n++;
            @(negedge clock);
        end
        check("t4_full_pp_count", 32'(n), 8);
        cons_ready = 1'b0;

        // Test 5: watchdog
        do_reset();
`ifdef HOST_WATCHDOG_EN
        repeat (19) @(negedge clock);
        check("t5_not_yet", 32'(done), 0);
        @(negedge clock);
        check("t5_done",    32'(done), 1);
        check("t5_timeout", 32'(timeout), 1);
        check("t5_pass",    32'(pass), 0);
        check("t5_exit",    32'(exit_code), 0);
        do_reset();
        repeat (19) @(negedge clock);
        write_bus(HOST_A, 4'hF, 32'h5);
        check("t5_race_done",    32'(done), 1);
        check("t5_race_timeout", 32'(timeout), 0);
        check("t5_race_exit",    32'(exit_code), 2);
`else
        repeat (40) @(negedge clock);
        check("t5_no_wd_timeout", 32'(timeout), 0);
        check("t5_no_wd_done",    32'(done), 0);
`endif

        // Test 6: reset mid-stream
        do_reset();
        cons_ready = 1'b0;
        for (int i = 0; i < 3; i++) write_bus(CONS_A + 2, 4'b0100, 32'(32'h0050_0000 + (i << 16)));
        write_bus(HOST_A, 4'hF, 32'h3);
        check("t6_pre_valid", 32'(cons_valid), 1);
        check("t6_pre_done",  32'(done), 1);
        reset = 1'b0;
        @(negedge clock);
        check("t6_rst_valid",    32'(cons_valid), 0);
        check("t6_rst_done",     32'(done), 0);
        check("t6_rst_pass",     32'(pass), 0);
        check("t6_rst_exit",     32'(exit_code), 0);
        check("t6_rst_overflow", 32'(overflow), 0);
        reset = 1'b1;
        write_bus(HOST_A, 4'hF, 32'h1);
        check("t6_rerun_done", 32'(done), 1);
        check("t6_rerun_pass", 32'(pass), 1);
        check("t6_rerun_exit", 32'(exit_code), 0);

        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
